// File: rtl/buf_reader.sv
// buf_reader: streams L words out of a synchronous-read buffer RAM through a 2-entry FIFO with a bypass path.
// Optional feature: define BUF_READER_ID_CHECK_EN to flag (sticky id_err) any returned word whose id >= NUM_COL.
module buf_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COL     = 10,
  parameter int BUFFER_SIZE = 512,
  localparam int IW = $clog2(NUM_COL) + 1,
  localparam int AW = $clog2(BUFFER_SIZE)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     unload,
  input  logic [AW:0]              len,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_addr,
  input  logic [DATA_WIDTH+IW-1:0] rd_data,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [IW-1:0]            id_out,
  output logic [AW-1:0]            addr_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     id_err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [AW:0]   LEN_MAX = (AW+1)'(BUFFER_SIZE);
  localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  state_t                state_q, state_d;
  logic [AW:0]           len_q, len_d;
  logic [AW:0]           issued_q, issued_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic [AW:0]           eff_len;
  logic                  inflight_q;
  logic [AW-1:0]         fl_addr_q;
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_data_q [2];
  logic [IW-1:0]         mem_id_q   [2];
  logic [AW-1:0]         mem_addr_q [2];
  logic                  fifo_nonempty, fifo_pop, push;

  assign eff_len = (len > LEN_MAX) ? LEN_MAX : len;

  // A returning word skips the FIFO when the FIFO is empty and the consumer takes it now.
  assign fifo_nonempty = (count_q != 2'd0);
  assign out_valid     = fifo_nonempty | inflight_q;
  assign fifo_pop      = fifo_nonempty & out_ready;
  assign push          = inflight_q & ~(~fifo_nonempty & out_ready);
  assign count_d       = count_q + {1'b0, push} - {1'b0, fifo_pop};

  assign rd_addr = rd_addr_q;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    rd_addr_d = rd_addr_q;
    rd_en     = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (unload) begin
          len_d     = eff_len;
          issued_d  = '0;
          rd_addr_d = '0;
          state_d   = (eff_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        // Never let buffered plus outstanding words exceed the two FIFO slots.
        if ((issued_q < len_q) && (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2)) begin
          rd_en     = 1'b1;
          issued_d  = issued_q + ONE_L;
          rd_addr_d = rd_addr_q + ONE_A;
        end
        if (issued_d == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // No reads issue here, so an empty FIFO next cycle also means nothing is in flight.
        if (count_d == 2'd0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= rd_en;
      count_q    <= count_d;
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) fl_addr_q <= rd_addr_q;
    if (push) begin
      mem_data_q[wr_ptr_q] <= rd_data[DATA_WIDTH+IW-1:IW];
      mem_id_q[wr_ptr_q]   <= rd_data[IW-1:0];
      mem_addr_q[wr_ptr_q] <= fl_addr_q;
    end
  end

  always_comb begin
    data_out = '0;
    id_out   = '0;
    addr_out = '0;
    if (fifo_nonempty) begin
      data_out = mem_data_q[rd_ptr_q];
      id_out   = mem_id_q[rd_ptr_q];
      addr_out = mem_addr_q[rd_ptr_q];
    end else if (inflight_q) begin
      data_out = rd_data[DATA_WIDTH+IW-1:IW];
      id_out   = rd_data[IW-1:0];
      addr_out = fl_addr_q;
    end
  end

`ifdef BUF_READER_ID_CHECK_EN
  localparam logic [IW-1:0] ID_LIMIT = IW'(NUM_COL);
  logic id_err_q;
  logic id_bad;
  assign id_bad = inflight_q & (rd_data[IW-1:0] >= ID_LIMIT);
  always_ff @(posedge clk) begin
    if (!rstn)       id_err_q <= 1'b0;
    else if (id_bad) id_err_q <= 1'b1;
  end
  assign id_err = id_err_q | id_bad;
`else
  assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_buf_reader.sv
// Directed bench for buf_reader: a 1-cycle-latency RAM model and a beat checker driven from one initial block.
module tb_buf_reader;
  localparam int DW = 16;
  localparam int NC = 10;
  localparam int BS = 512;
  localparam int IW = $clog2(NC) + 1;
  localparam int AW = $clog2(BS);
`ifdef BUF_READER_ID_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn, unload, out_ready;
  logic [AW:0] len;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW+IW-1:0] rd_data = '0;
  logic [DW-1:0] data_out;
  logic [IW-1:0] id_out;
  logic [AW-1:0] addr_out;
  logic out_valid, busy, done, id_err;

  int errors = 0;
  int checks = 0;
  logic bad_id = 1'b0;
  int cyc, outst, beats, exp_addr, last_addr, rd_cnt, done_cnt, done_cyc;
  int first_valid_cyc, last_beat_cyc, ready_mode;
  logic stall_prev;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic [IW-1:0] prev_id;

  always #5 clk = ~clk;

  buf_reader #(.DATA_WIDTH(DW), .NUM_COL(NC), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .rstn(rstn), .unload(unload), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .data_out(data_out), .id_out(id_out), .addr_out(addr_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .id_err(id_err)
  );

  function automatic int exp_id(input int a);
    return (bad_id && a == 2) ? 12 : a % 10;
  endfunction

  function automatic logic [DW+IW-1:0] ram_word(input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    return {DW'(ai + 100), IW'(exp_id(ai))};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= ram_word(rd_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rd_en) begin
      rd_cnt++;
      check("rd_en_with_room", 64'(outst < 2), 64'd1);
      check("rd_addr_seq", 64'(rd_addr), 64'(rd_cnt - 1));
    end
    if (stall_prev) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(data_out), 64'(prev_data));
      check("hold_addr", 64'(addr_out), 64'(prev_addr));
      check("hold_id", 64'(id_out), 64'(prev_id));
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      check("beat_addr", 64'(addr_out), 64'(exp_addr));
      check("beat_data", 64'(data_out), 64'(exp_addr + 100));
      check("beat_id", 64'(id_out), 64'(exp_id(exp_addr)));
      check("beat_id_err", 64'(id_err), 64'((bad_id && exp_addr >= 2) ? EXP_ERR : 1'b0));
      last_addr = int'(addr_out);
      last_beat_cyc = cyc;
      beats++;
      exp_addr++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    outst = outst + (rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    stall_prev = out_valid && !out_ready;
    prev_data = data_out;
    prev_addr = addr_out;
    prev_id = id_out;
    @(posedge clk);
    #1;
    cyc++;
    out_ready = (ready_mode == 0) || (cyc % 3 == 0);
  endtask

  task automatic run_xfer(input int l, input int mode, input int budget,
                          input int poke_cyc, input int stop_beats);
    cyc = 0; outst = 0; beats = 0; exp_addr = 0; last_addr = -1; rd_cnt = 0;
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1;
    stall_prev = 1'b0; ready_mode = mode;
    len = (AW+1)'(l);
    unload = 1'b1;
    out_ready = 1'b1;
    tick();
    unload = 1'b0;
    while (done_cnt == 0 && cyc < budget && !(stop_beats > 0 && beats >= stop_beats)) begin
      if (cyc == poke_cyc) begin
        unload = 1'b1;
        len = (AW+1)'(2);
      end else begin
        unload = 1'b0;
      end
      tick();
    end
    unload = 1'b0;
    if (stop_beats == 0) check("done_seen", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; unload = 1'b0; len = '0; out_ready = 1'b0; ready_mode = 0;
    cyc = 0; outst = 0; stall_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_id_out", 64'(id_out), 64'd0);
    check("rst_addr_out", 64'(addr_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_id_err", 64'(id_err), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // len=5 with continuous ready
    run_xfer(5, 0, 40, -1, 0);
    check("l5_beats", 64'(beats), 64'd5);
    check("l5_first_valid", 64'(first_valid_cyc), 64'd2);
    check("l5_last_beat", 64'(last_beat_cyc), 64'd6);
    check("l5_done_cyc", 64'(done_cyc), 64'd7);
    check("l5_reads", 64'(rd_cnt), 64'd5);
    check("l5_idle_busy", 64'(busy), 64'd0);

    // len=8 right after DONE, ready 1,0,0 repeating, stray unload while busy
    run_xfer(8, 1, 80, 4, 0);
    check("l8_beats", 64'(beats), 64'd8);
    check("l8_last_addr", 64'(last_addr), 64'd7);
    check("l8_first_valid", 64'(first_valid_cyc), 64'd2);
    check("l8_reads", 64'(rd_cnt), 64'd8);
    tick();
    check("l8_single_done", 64'(done_cnt), 64'd1);
    check("l8_idle_busy", 64'(busy), 64'd0);

    // len=0
    run_xfer(0, 0, 10, -1, 0);
    check("l0_done_cyc", 64'(done_cyc), 64'd1);
    check("l0_reads", 64'(rd_cnt), 64'd0);
    check("l0_no_valid", 64'(first_valid_cyc), 64'(-1));
    check("l0_beats", 64'(beats), 64'd0);

    // len beyond buffer depth
    run_xfer(600, 0, 700, -1, 0);
    check("l600_beats", 64'(beats), 64'd512);
    check("l600_last_addr", 64'(last_addr), 64'd511);
    check("l600_reads", 64'(rd_cnt), 64'd512);
    check("l600_done_cyc", 64'(done_cyc), 64'd514);

    // reset after third beat of len=10
    run_xfer(10, 0, 40, -1, 3);
    check("abort_beats", 64'(beats), 64'd3);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_rd_addr", 64'(rd_addr), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_data_out", 64'(data_out), 64'd0);
    check("abort_id_out", 64'(id_out), 64'd0);
    check("abort_addr_out", 64'(addr_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
      check("abort_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    run_xfer(2, 0, 20, -1, 0);
    check("fresh_beats", 64'(beats), 64'd2);
    check("fresh_last_addr", 64'(last_addr), 64'd1);
    check("fresh_first_valid", 64'(first_valid_cyc), 64'd2);

    // word 2 carries an out-of-range id
    bad_id = 1'b1;
    run_xfer(5, 0, 40, -1, 0);
    check("id_beats", 64'(beats), 64'd5);
    check("id_err_after", 64'(id_err), 64'(EXP_ERR));
    tick();
    check("id_err_sticky", 64'(id_err), 64'(EXP_ERR));
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("id_err_reset", 64'(id_err), 64'd0);
    rstn = 1'b1;
    bad_id = 1'b0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
